// File: rtl/tick_event_scheduler_if.sv
// Event handshake between the tick scheduler (master) and the stat-update FSM (slave).
// The master offers one channel index at a time; the slave accepts it with ev_ack.
interface tick_event_scheduler_if #(
    parameter int NCH = 4
) ();
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic          ev_valid;
    logic [CW-1:0] ev_ch;
    logic          ev_ack;

    modport master (output ev_valid, output ev_ch, input ev_ack);
    modport slave  (input ev_valid, input ev_ch, output ev_ack);
endinterface

// File: rtl/tick_event_scheduler.sv
// Tick event scheduler: NCH periodic pet-state timers share the game tick and raise
// pending events, which a round-robin arbiter offers one at a time over a valid/ack
// handshake.
// Optional build macro FAST_FWD_EN: adds input ff; while ff=1 every clk cycle counts
// as a tick (still gated by enable).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no event offered; grants the next pending channel after last
//   OFFER | ev_valid=1 with ev_ch held until the consumer acks
module tick_event_scheduler #(
    parameter int NCH = 4,
    parameter int PW  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef FAST_FWD_EN
    input  logic                   ff,
`endif
    input  logic                   tick,
    input  logic                   enable,
    input  logic [NCH*PW-1:0]      period_i,
    output logic [NCH-1:0]         pending,
    output logic [NCH-1:0]         overrun,
    tick_event_scheduler_if.master ev
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, OFFER} state_t;

    state_t        state;
    logic          adv;
    logic          ack_fire;
    logic [NCH-1:0] expire;
    logic          ev_valid_r;
    logic [CW-1:0] ev_ch_r;
    logic [CW-1:0] last;
    logic [CW-1:0] grant;
    logic [CW-1:0] idx;
    logic          found;

`ifdef FAST_FWD_EN
    assign adv = (tick | ff) & enable;
`else
    assign adv = tick & enable;
`endif

    // OFFER is the only state with ev_valid=1, so an ack outside it is ignored.
    assign ack_fire = ev_valid_r & ev.ev_ack;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [PW-1:0] per;
        logic [PW-1:0] cnt;
        logic [PW:0]   nxt;

        assign per = period_i[k*PW +: PW];
        // One extra bit so cnt+1 never wraps before the compare.
        assign nxt = {1'b0, cnt} + (PW+1)'(1);
        assign expire[k] = adv && (per != '0) && (nxt >= {1'b0, per});

        // Per-channel tick counter; a disabled channel is parked at zero.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (per == '0) begin
                cnt <= '0;
            end else if (adv) begin
                cnt <= expire[k] ? '0 : nxt[PW-1:0];
            end
        end
    end

    // Pending/overrun flags: expiry sets pending; an ack of the same channel in the
    // same cycle counts as a fresh event rather than a lost one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (expire[k]) begin
                    if (pending[k] && !(ack_fire && ev_ch_r == CW'(k)))
                        overrun[k] <= 1'b1;
                    pending[k] <= 1'b1;
                end else if (ack_fire && ev_ch_r == CW'(k)) begin
                    pending[k] <= 1'b0;
                end
            end
        end
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = CW'((int'(last) + i) % NCH);
            if (!found && pending[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    // Arbiter FSM with registered ev_valid/ev_ch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ev_valid_r <= 1'b0;
            ev_ch_r    <= '0;
            last       <= CW'(NCH - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        ev_ch_r    <= grant;
                        ev_valid_r <= 1'b1;
                        state      <= OFFER;
                    end
                end
                OFFER: begin
                    if (ev.ev_ack) begin
                        last       <= ev_ch_r;
                        ev_valid_r <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ev_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ev.ev_valid = ev_valid_r;
    assign ev.ev_ch    = ev_ch_r;

endmodule
